// File: rtl/piso_sched_pkg.sv
// Shared types and helpers for the round-robin parallel-in/serial-out scheduler.
package piso_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);
  localparam int GAP_W         = 4;

  // $clog2 that never returns 0, so vectors keep at least one bit.
  function automatic int clog2_safe(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with wrap-around.
module rr_arbiter
  import piso_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]             req,
  input  logic [clog2_safe(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]             grant,
  output logic [clog2_safe(N_REQ)-1:0] grant_idx,
  output logic                         any
);

  localparam int IDX_W = clog2_safe(N_REQ);

  // Offset 1 is the requester just after the last winner, so it has top priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/piso_rr_scheduler.sv
// Shares one LSB-first serializer among N_REQ requesters with round-robin grants
// and a programmable idle gap after every frame.
module piso_rr_scheduler
  import piso_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     stall,
  output logic                     ser_out,
  output logic                     ser_valid,
  output logic                     ser_last,
  output logic [$clog2(N_REQ)-1:0] ser_src,
  output logic                     busy
);

  localparam int IDX_W    = clog2_safe(N_REQ);
  localparam int CNT_BITS = (WIDTH == DEFAULT_WIDTH) ? CNT_W : clog2_safe(WIDTH);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WIDTH - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    src_q, src_d;

  logic [N_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      rr_ptr_q <= IDX_W'(N_REQ - 1);
      src_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
    end
  end

  // Stall freezes every state element, whichever state we are in.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    rr_ptr_d = rr_ptr_q;
    src_d    = src_q;
    unique case (state_q)
      IDLE: begin
        if (!stall && arb_any) begin
          shift_d  = req_data[arb_idx*WIDTH +: WIDTH];
          rr_ptr_d = arb_idx;
          src_d    = arb_idx;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (!stall) begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            gap_d   = '0;
            state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
      end
      GAP: begin
        if (!stall) begin
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    ser_last  = 1'b0;
    if (state_q == IDLE && !stall) begin
      req_ready = arb_grant;
    end
    if (state_q == SHIFT && !stall) begin
      ser_valid = 1'b1;
      ser_out   = shift_q[0];
      ser_last  = (cnt_q == CNT_LAST);
    end
  end

  assign busy    = (state_q != IDLE);
  assign ser_src = src_q;

endmodule

// File: tb/tb_piso_rr_scheduler.sv
// Scoreboard bench: stimulus pushes expected serial bits, a negedge monitor pops and compares.
module tb_piso_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        stall;
  logic        ser_out, ser_valid, ser_last, busy;
  logic [1:0]  ser_src;

  logic [3:0]  g0_valid;
  logic [15:0] g0_data;
  logic [3:0]  g0_ready;
  logic        g0_out, g0_ser_valid, g0_last, g0_busy;
  logic [1:0]  g0_src;

  typedef struct {
    logic       bit_v;
    logic       last;
    logic [1:0] src;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   grant_seq[5];

  always #5 clk = ~clk;

  piso_rr_scheduler #(.N_REQ(4), .WIDTH(4), .GAP_CYCLES(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .stall     (stall),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_last  (ser_last),
    .ser_src   (ser_src),
    .busy      (busy)
  );

  piso_rr_scheduler #(.N_REQ(4), .WIDTH(4), .GAP_CYCLES(0)) dut_g0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (g0_valid),
    .req_data  (g0_data),
    .req_ready (g0_ready),
    .stall     (1'b0),
    .ser_out   (g0_out),
    .ser_valid (g0_ser_valid),
    .ser_last  (g0_last),
    .ser_src   (g0_src),
    .busy      (g0_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushWord(input int src, input logic [3:0] word);
    for (int b = 0; b < 4; b++) begin
      exp_t e;
      e.bit_v = word[b];
      e.last  = (b == 3);
      e.src   = 2'(src);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (ser_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_bit got ser_out=%0b src=%0d expected no valid bit at %0t",
                 ser_out, ser_src, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("ser_out", 32'(ser_out), 32'(e.bit_v));
        checkOutput("ser_last", 32'(ser_last), 32'(e.last));
        checkOutput("ser_src", 32'(ser_src), 32'(e.src));
      end
    end
  end

  // Drives the request vector and waits for n grants in the order held in grant_seq.
  task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] data, input int n);
    int waited;
    req_data  = data;
    req_valid = valid;
    #1;
    for (int g = 0; g < n; g++) begin
      waited = 0;
      while (!(|(req_ready & req_valid)) && waited < 50) begin
        @(posedge clk);
        #2;
        waited++;
      end
      if (waited >= 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL grant_timeout got no grant expected requester %0d", grant_seq[g]);
        req_valid = '0;
        return;
      end
      checkOutput("req_ready_grant", 32'(req_ready), 32'(1) << grant_seq[g]);
      pushWord(grant_seq[g], data[grant_seq[g]*4 +: 4]);
      @(posedge clk);
      #1;
      if (g == n - 1) req_valid = '0;
      #1;
      checkOutput("req_ready_after_grant", 32'(req_ready), 32'd0);
      checkOutput("busy_after_grant", 32'(busy), 32'd1);
    end
  endtask

  task automatic waitIdle(input int exp_edges);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_edges >= 0) begin
      checkOutput("idle_edges", 32'(n), 32'(exp_edges));
    end else if (n >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout got busy after %0d edges expected idle", n);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got no finish expected completion by %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    stall     = 1'b0;
    g0_valid  = '0;
    g0_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ser_valid", 32'(ser_valid), 32'd0);
    checkOutput("reset_ser_out", 32'(ser_out), 32'd0);
    checkOutput("reset_ser_last", 32'(ser_last), 32'd0);
    checkOutput("reset_ser_src", 32'(ser_src), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);

    $display("[TB] single word");
    grant_seq[0] = 0;
    applyStimulus(4'b0001, 16'h000B, 1);
    waitIdle(5);

    $display("[TB] round robin");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    grant_seq = '{0, 1, 2, 3, 0};
    applyStimulus(4'b1111, 16'h4321, 5);
    waitIdle(5);

    $display("[TB] wrap and skip");
    grant_seq[0] = 2;
    applyStimulus(4'b0100, 16'h0500, 1);
    waitIdle(5);
    grant_seq[0] = 3;
    grant_seq[1] = 1;
    applyStimulus(4'b1010, 16'h9060, 2);
    waitIdle(5);

    $display("[TB] stall");
    stall     = 1'b1;
    req_valid = 4'b0001;
    req_data  = 16'h0006;
    #1;
    checkOutput("stall_idle_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #2;
    checkOutput("stall_idle_busy", 32'(busy), 32'd0);
    checkOutput("stall_idle_ready2", 32'(req_ready), 32'd0);
    stall = 1'b0;
    grant_seq[0] = 0;
    applyStimulus(4'b0001, 16'h0006, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_ser_valid", 32'(ser_valid), 32'd0);
      checkOutput("stall_ser_last", 32'(ser_last), 32'd0);
      checkOutput("stall_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    waitIdle(-1);

    $display("[TB] reset mid-frame");
    grant_seq[0] = 1;
    applyStimulus(4'b0010, 16'h00F0, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("abort_ser_valid", 32'(ser_valid), 32'd0);
    checkOutput("abort_ser_out", 32'(ser_out), 32'd0);
    checkOutput("abort_ser_last", 32'(ser_last), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ser_src", 32'(ser_src), 32'd0);
    grant_seq[0] = 0;
    applyStimulus(4'b0101, 16'h0008, 1);
    waitIdle(5);

    $display("[TB] zero gap build");
    g0_data  = 16'h0035;
    g0_valid = 4'b0011;
    begin
      int waited;
      waited = 0;
      @(negedge clk);
      while (!g0_ser_valid && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 20) begin
        checks++;
        errors++;
        $display("[TB] FAIL g0_start_timeout got no valid bit expected one within 20 cycles");
      end else begin
        for (int k = 0; k < 10; k++) begin
          checkOutput("g0_ser_valid", 32'(g0_ser_valid), 32'((k % 5) != 4));
          if (k == 0) checkOutput("g0_src_first", 32'(g0_src), 32'd0);
          if (k == 5) checkOutput("g0_src_second", 32'(g0_src), 32'd1);
          @(negedge clk);
        end
      end
    end
    g0_valid = '0;
    repeat (12) @(posedge clk);
    #1;

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
